// File: rtl/comp2_mult_pkg.sv
// Shared types and defaults for the sequential two's-complement multiplier.
package comp2_mult_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned D2W_DEF = 2 * DW_DEF;

  typedef logic [DW_DEF-1:0]  operand_t;
  typedef logic [DW_DEF-1:0]  magnitude_t;
  typedef logic [D2W_DEF-1:0] product_t;
  typedef logic               sign_t;

  typedef struct packed {
    magnitude_t magnitude;
    sign_t      sign;
  } sm_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/comp2_to_sm.sv
// Combinational two's-complement to sign/magnitude converter.
// The most negative value maps to its exact unsigned magnitude (e.g. -128 -> 128).
module comp2_to_sm
  import comp2_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] value,
  output logic [DW-1:0] magnitude,
  output logic          sign
);

  assign sign      = value[DW-1];
  assign magnitude = sign ? (~value + DW'(1)) : value;

endmodule

// File: rtl/comp2_seq_mult.sv
// Sequential signed multiplier: sign/magnitude conversion, one-bit-per-cycle
// shift-and-add on the magnitudes, then sign application.
// Optional build macro COMP2_MULT_EARLY_EXIT_EN: leave MULT as soon as the
// remaining multiplier bits are all zero (product value is unchanged).
module comp2_seq_mult
  import comp2_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [2*DW-1:0] product_o,
  output logic            sign_o
);

  localparam int unsigned D2W = 2 * DW;
  localparam int unsigned CW  = $clog2(DW);

  state_t          state, state_nxt;
  logic [DW-1:0]   mcand, mcand_nxt;
  logic [DW-1:0]   mplr, mplr_nxt;
  logic [D2W-1:0]  acc, acc_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            sign_a, sign_a_nxt;
  logic            sign_b, sign_b_nxt;
  logic [D2W-1:0]  product_nxt;
  logic            sign_nxt, busy_nxt, done_nxt;
  logic            last_bit, neg;

  logic [DW-1:0]   a_mag, b_mag;
  logic            a_sign, b_sign;

  comp2_to_sm #(.DW(DW)) u_conv_a (.value(a_i), .magnitude(a_mag), .sign(a_sign));
  comp2_to_sm #(.DW(DW)) u_conv_b (.value(b_i), .magnitude(b_mag), .sign(b_sign));

  // State, datapath and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      count     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      product_o <= '0;
      sign_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      mplr      <= mplr_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      sign_a    <= sign_a_nxt;
      sign_b    <= sign_b_nxt;
      product_o <= product_nxt;
      sign_o    <= sign_nxt;
      busy_o    <= busy_nxt;
      done_o    <= done_nxt;
    end
  end

  // Next-state and next-output logic; busy/done are derived from the state being entered.
  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    mplr_nxt    = mplr;
    acc_nxt     = acc;
    count_nxt   = count;
    sign_a_nxt  = sign_a;
    sign_b_nxt  = sign_b;
    product_nxt = product_o;
    sign_nxt    = sign_o;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    last_bit    = 1'b0;
    neg         = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          mcand_nxt  = a_mag;
          mplr_nxt   = b_mag;
          sign_a_nxt = a_sign;
          sign_b_nxt = b_sign;
          acc_nxt    = '0;
          count_nxt  = '0;
          state_nxt  = MULT;
          busy_nxt   = 1'b1;
        end
      end
      MULT: begin
        if (mplr[0]) begin
          acc_nxt = acc + (D2W'(mcand) << count);
        end
        mplr_nxt  = mplr >> 1;
        count_nxt = count + CW'(1);
        last_bit  = (count == CW'(DW - 1));
`ifdef COMP2_MULT_EARLY_EXIT_EN
        last_bit  = last_bit || (mplr[DW-1:1] == '0);
`endif
        if (last_bit) begin
          state_nxt = SIGN;
        end
        busy_nxt  = 1'b1;
      end
      SIGN: begin
        // A zero product is always reported as positive.
        neg         = (sign_a ^ sign_b) && (acc != '0);
        product_nxt = neg ? (~acc + D2W'(1)) : acc;
        sign_nxt    = neg;
        state_nxt   = DONE;
        done_nxt    = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_comp2_seq_mult.sv
// Scoreboard bench for comp2_seq_mult: driver pushes model results, monitor checks on done_o.
module tb_comp2_seq_mult;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic          busy_o, done_o, sign_o;
  logic [PW-1:0] product_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] product;
    logic          sign;
    int            accept;
    int            lat;
  } exp_t;

  exp_t exp_q[$];

  comp2_seq_mult #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o),
    .sign_o    (sign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed multiplication; latency from the magnitude of b.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input int accept);
    exp_t r;
    logic signed [PW-1:0] pa, pb;
    int bi, ab, h;
    pa = {{DW{a[DW-1]}}, a};
    pb = {{DW{b[DW-1]}}, b};
    r.a = a;
    r.b = b;
    r.product = pa * pb;
    r.sign = r.product[PW-1];
    r.accept = accept;
    bi = int'($signed(b));
    ab = (bi < 0) ? -bi : bi;
    h = 0;
    for (int k = 0; k < 32; k++) if (((ab >> k) & 1) == 1) h = k;
`ifdef COMP2_MULT_EARLY_EXIT_EN
    r.lat = 3 + h;
`else
    r.lat = DW + 2;
`endif
    return r;
  endfunction

  // Monitor: checks product, sign, latency, busy length, and hold/pulse width afterwards.
  initial begin
    exp_t e;
    int busy_cnt;
    logic hold_pending;
    logic [PW-1:0] held_p;
    logic held_s;
    busy_cnt = 0;
    hold_pending = 1'b0;
    held_p = '0;
    held_s = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("held_product", product_o, held_p);
          check("held_sign", PW'(sign_o), PW'(held_s));
          check("done_pulse_width", PW'(done_o), PW'(0));
          hold_pending = 1'b0;
        end
        if (busy_o) busy_cnt++;
        if (done_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_o=1 expected no pending operation");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("product a=%h b=%h", e.a, e.b), product_o, e.product);
            check($sformatf("sign a=%h b=%h", e.a, e.b), PW'(sign_o), PW'(e.sign));
            check($sformatf("latency a=%h b=%h", e.a, e.b), PW'(cyc - e.accept + 1), PW'(e.lat));
            check($sformatf("busy_cycles a=%h b=%h", e.a, e.b), PW'(busy_cnt), PW'(e.lat - 1));
            held_p = e.product;
            held_s = e.sign;
            hold_pending = 1'b1;
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Driver helpers (called at a negedge, return at a negedge).
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b, cyc));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 4 * DW + 10) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o expected done within %0d cycles", 4 * DW + 10);
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    exp_t e;
    int next_accept;

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", PW'(busy_o), PW'(0));
    check("reset_done", PW'(done_o), PW'(0));
    check("reset_product", product_o, PW'(0));
    check("reset_sign", PW'(sign_o), PW'(0));
    rst = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(8'd3, 8'd5);
    run_op(8'hF9, 8'd6);
    run_op(8'h80, 8'h80);
    run_op(8'h80, 8'h7F);
    run_op(8'd0, 8'hFB);
    run_op(8'd9, 8'd1);
    run_op(8'h7F, 8'h80);

    // Start re-pulsed mid-MULT is ignored
    issue(8'd3, 8'd5);
    @(negedge clk);
    a_i = 8'd9;
    b_i = 8'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // Async reset during MULT clears outputs immediately
    issue(8'd5, 8'h7F);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_busy", PW'(busy_o), PW'(0));
    check("midreset_done", PW'(done_o), PW'(0));
    check("midreset_product", product_o, PW'(0));
    check("midreset_sign", PW'(sign_o), PW'(0));
    exp_q.delete(exp_q.size() - 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(8'd2, 8'hFE);

    // start_i held high: back-to-back operations
    a_i = 8'($urandom);
    b_i = 8'($urandom);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    e = model(a_i, b_i, cyc);
    exp_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      next_accept = e.accept + e.lat + 1;
      @(negedge clk);
      a_i = 8'($urandom);
      b_i = 8'($urandom);
      e = model(a_i, b_i, next_accept);
      exp_q.push_back(e);
      while (cyc < next_accept) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // Randomized operands
    for (int k = 0; k < 20; k++) begin
      run_op(8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", PW'(exp_q.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
